// File: rtl/rib_pkg.sv
// Shared RIB definitions: field widths, master IDs, arbitration modes, response entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rib_pkg;

    localparam int RIB_MASK_W = 4;
    localparam int RIB_DATA_W = 32;

    // Arbitration policy selectors for the arbiter's PRIO_MODE parameter
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Master identifier: 0 = core data port, 1 = secondary master (DMA/debug)
    typedef logic mid_t;
    localparam mid_t MID_M0 = 1'b0;
    localparam mid_t MID_M1 = 1'b1;

    // Buffered response: owner plus the read data captured from the slave
    typedef struct packed {
        mid_t                  id;
        logic [RIB_DATA_W-1:0] rdata;
    } rsp_ent_t;

endpackage

// File: rtl/rib_sync_fifo.sv
// Generic synchronous FIFO with registered storage and a combinational head.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller sizes traffic.
//
// Ports: i_clk/i_rst clock and async active-high reset; push/push_dat write side;
//        pop read side; head current oldest entry; count/full/empty occupancy.
module rib_sync_fifo #(
    parameter int  WIDTH = 1,
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rib_tcm_arbiter.sv
// Two-master RIB arbiter sharing one TCM controller; routes responses back to their owner.
// Latency: request path combinational; response bypassed in the slave-rsp cycle, else served from buffer.
// Backpressure: master rdy=0 parks responses in a credit-sized buffer; requests withheld when credits run out.
//
// Ports: i_clk, i_rst (async active-high);
//        per master X: i_mX_addr/wrcs/mask/wdata/req request, o_mX_gnt accept,
//                      o_mX_rsp/o_mX_rdata response, i_mX_rdy response ready;
//        slave: o_s_addr/wrcs/mask/wdata/req request, i_s_gnt accept,
//               i_s_rsp/i_s_rdata response, o_s_rdy (always 1);
//        o_proto_err sticky flag for a slave response with nothing in flight.
module rib_tcm_arbiter
    import rib_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int MAX_OUT   = 2,
    parameter int AW        = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic [AW-1:0]         i_m0_addr,
    input  logic                  i_m0_wrcs,
    input  logic [RIB_MASK_W-1:0] i_m0_mask,
    input  logic [RIB_DATA_W-1:0] i_m0_wdata,
    input  logic                  i_m0_req,
    output logic                  o_m0_gnt,
    output logic                  o_m0_rsp,
    output logic [RIB_DATA_W-1:0] o_m0_rdata,
    input  logic                  i_m0_rdy,

    input  logic [AW-1:0]         i_m1_addr,
    input  logic                  i_m1_wrcs,
    input  logic [RIB_MASK_W-1:0] i_m1_mask,
    input  logic [RIB_DATA_W-1:0] i_m1_wdata,
    input  logic                  i_m1_req,
    output logic                  o_m1_gnt,
    output logic                  o_m1_rsp,
    output logic [RIB_DATA_W-1:0] o_m1_rdata,
    input  logic                  i_m1_rdy,

    output logic [AW-1:0]         o_s_addr,
    output logic                  o_s_wrcs,
    output logic [RIB_MASK_W-1:0] o_s_mask,
    output logic [RIB_DATA_W-1:0] o_s_wdata,
    output logic                  o_s_req,
    input  logic                  i_s_gnt,
    input  logic                  i_s_rsp,
    input  logic [RIB_DATA_W-1:0] i_s_rdata,
    output logic                  o_s_rdy,

    output logic                  o_proto_err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] inflight_cnt;
    logic [CNT_W-1:0] resp_cnt;
    logic [CNT_W:0]   credits_used;
    logic             id_full, id_empty;
    logic             rq_full, rq_empty;
    mid_t             id_head;
    rsp_ent_t         rq_head;
    rsp_ent_t         rq_push_ent;

    mid_t             rr_last;
    mid_t             winner;
    logic             credit_ok;
    logic             cand0, cand1;
    logic             accept;

    logic             s_rsp_ok;
    logic             owner_rdy;
    logic             head_rdy;
    logic             bypass;
    logic             rq_push;
    logic             rq_pop;

    logic [RIB_DATA_W-1:0] rd0_q, rd1_q;
    logic                  proto_err_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        credits_used = {1'b0, inflight_cnt} + {1'b0, resp_cnt};
        // The full flags are implied by the credit sum; folding them in keeps
        // both FIFOs safe from overrun even if the counts were ever to disagree.
        credit_ok = (credits_used < (CNT_W + 1)'(MAX_OUT)) & ~id_full & ~rq_full;

        // Slave request is held low while reset is asserted.
        cand0 = i_m0_req & credit_ok & ~i_rst;
        cand1 = i_m1_req & credit_ok & ~i_rst;

        winner = MID_M0;
        if (cand0 && cand1) begin
            winner = (PRIO_MODE == PRIO_FIXED) ? MID_M0 : ~rr_last;
        end else if (cand1) begin
            winner = MID_M1;
        end

        o_s_req   = cand0 | cand1;
        o_s_addr  = (winner == MID_M1) ? i_m1_addr  : i_m0_addr;
        o_s_wrcs  = (winner == MID_M1) ? i_m1_wrcs  : i_m0_wrcs;
        o_s_mask  = (winner == MID_M1) ? i_m1_mask  : i_m0_mask;
        o_s_wdata = (winner == MID_M1) ? i_m1_wdata : i_m0_wdata;

        accept   = o_s_req & i_s_gnt;
        o_m0_gnt = accept & (winner == MID_M0);
        o_m1_gnt = accept & (winner == MID_M1);
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        s_rsp_ok    = i_s_rsp & ~id_empty;
        owner_rdy   = (id_head == MID_M1) ? i_m1_rdy : i_m0_rdy;
        // Bypass only when nothing older is waiting, so order is preserved.
        bypass      = s_rsp_ok & rq_empty & owner_rdy;
        rq_push     = s_rsp_ok & ~bypass;
        rq_push_ent = '{id: id_head, rdata: i_s_rdata};

        head_rdy = (rq_head.id == MID_M1) ? i_m1_rdy : i_m0_rdy;
        rq_pop   = ~rq_empty & head_rdy;

        o_m0_rsp   = 1'b0;
        o_m1_rsp   = 1'b0;
        o_m0_rdata = rd0_q;
        o_m1_rdata = rd1_q;
        if (!rq_empty) begin
            if (rq_head.id == MID_M1) begin
                o_m1_rsp   = 1'b1;
                o_m1_rdata = rq_head.rdata;
            end else begin
                o_m0_rsp   = 1'b1;
                o_m0_rdata = rq_head.rdata;
            end
        end else if (bypass) begin
            if (id_head == MID_M1) begin
                o_m1_rsp   = 1'b1;
                o_m1_rdata = i_s_rdata;
            end else begin
                o_m0_rsp   = 1'b1;
                o_m0_rdata = i_s_rdata;
            end
        end
    end

    assign o_s_rdy     = 1'b1;
    assign o_proto_err = proto_err_q;

    // rr_last resets to m1 so that m0 wins the first conflict.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_last     <= MID_M1;
            proto_err_q <= 1'b0;
            rd0_q       <= '0;
            rd1_q       <= '0;
        end else begin
            if (accept) begin
                rr_last <= winner;
            end
            if (i_s_rsp && id_empty) begin
                proto_err_q <= 1'b1;
            end
            // Keep the last delivered data on the bus while rsp is low.
            if (o_m0_rsp) begin
                rd0_q <= o_m0_rdata;
            end
            if (o_m1_rsp) begin
                rd1_q <= o_m1_rdata;
            end
        end
    end

    // Owner of each in-flight transaction, oldest first.
    rib_sync_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (accept),
        .push_dat (winner),
        .pop      (s_rsp_ok),
        .head     (id_head),
        .count    (inflight_cnt),
        .full     (id_full),
        .empty    (id_empty)
    );

    // Responses waiting for their owner to become ready.
    rib_sync_fifo #(
        .WIDTH ($bits(rsp_ent_t)),
        .DEPTH (MAX_OUT)
    ) u_rsp_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (rq_push),
        .push_dat (rq_push_ent),
        .pop      (rq_pop),
        .head     (rq_head),
        .count    (resp_cnt),
        .full     (rq_full),
        .empty    (rq_empty)
    );

endmodule

// File: tb/tb_rib_tcm_arbiter.sv
// Bench for rib_tcm_arbiter: two instances (round-robin and fixed priority) on shared master inputs.
// Latency: checks sampled on the falling edge; directed expectations sampled 3 time units after the rising edge.
// Backpressure: bench acts as slave (rsp one cycle after gnt) and drives random master rdy.
module tb_rib_tcm_arbiter;

    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared master-side stimulus
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_wrcs, m1_wrcs, m0_req, m1_req, m0_rdy, m1_rdy;

    // per-instance slave side and outputs (index 0 = round-robin, 1 = fixed)
    logic        s_gnt [2];
    logic        s_rsp [2];
    logic [31:0] s_rdata [2];
    logic        m0_gnt [2], m1_gnt [2], m0_rsp [2], m1_rsp [2];
    logic [31:0] m0_rd [2], m1_rd [2];
    logic [31:0] s_addr [2], s_wdata [2];
    logic [3:0]  s_mask [2];
    logic        s_wrcs [2], s_req [2], s_rdy [2], perr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rib_tcm_arbiter #(
            .PRIO_MODE (g),
            .MAX_OUT   (MAX_OUT),
            .AW        (32)
        ) dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_m0_addr   (m0_addr),
            .i_m0_wrcs   (m0_wrcs),
            .i_m0_mask   (m0_mask),
            .i_m0_wdata  (m0_wdata),
            .i_m0_req    (m0_req),
            .o_m0_gnt    (m0_gnt[g]),
            .o_m0_rsp    (m0_rsp[g]),
            .o_m0_rdata  (m0_rd[g]),
            .i_m0_rdy    (m0_rdy),
            .i_m1_addr   (m1_addr),
            .i_m1_wrcs   (m1_wrcs),
            .i_m1_mask   (m1_mask),
            .i_m1_wdata  (m1_wdata),
            .i_m1_req    (m1_req),
            .o_m1_gnt    (m1_gnt[g]),
            .o_m1_rsp    (m1_rsp[g]),
            .o_m1_rdata  (m1_rd[g]),
            .i_m1_rdy    (m1_rdy),
            .o_s_addr    (s_addr[g]),
            .o_s_wrcs    (s_wrcs[g]),
            .o_s_mask    (s_mask[g]),
            .o_s_wdata   (s_wdata[g]),
            .o_s_req     (s_req[g]),
            .i_s_gnt     (s_gnt[g]),
            .i_s_rsp     (s_rsp[g]),
            .i_s_rdata   (s_rdata[g]),
            .o_s_rdy     (s_rdy[g]),
            .o_proto_err (perr[g])
        );
    end

    // ---------------- reference model state ----------------
    bit          rr_last [2];
    int          inf_n [2];
    bit          inf_id [2][8];
    int          buf_n [2];
    bit          buf_id [2][8];
    logic [31:0] buf_dat [2][8];
    logic [31:0] last_rd [2][2];
    bit          perr_m [2];

    // slave behaviour
    bit          pend_rsp [2];
    logic [31:0] pend_dat [2];
    int          dmode;
    int          bp_idx [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", k, nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        rr_last[k]    = 1'b1;
        inf_n[k]      = 0;
        buf_n[k]      = 0;
        last_rd[k][0] = '0;
        last_rd[k][1] = '0;
        perr_m[k]     = 1'b0;
    endtask

    task automatic chk_reset_outs(input int k);
        chk(k, "rst_s_req", 32'(s_req[k]), 0);
        chk(k, "rst_gnt0",  32'(m0_gnt[k]), 0);
        chk(k, "rst_gnt1",  32'(m1_gnt[k]), 0);
        chk(k, "rst_rsp0",  32'(m0_rsp[k]), 0);
        chk(k, "rst_rsp1",  32'(m1_rsp[k]), 0);
        chk(k, "rst_rd0",   m0_rd[k], 0);
        chk(k, "rst_rd1",   m1_rd[k], 0);
        chk(k, "rst_perr",  32'(perr[k]), 0);
    endtask

    // One cycle of the behavioural model: predict outputs, compare, advance.
    task automatic model_step(input int k);
        bit          credit, c0, c1, e_sreq, win, acc;
        bit          pop_b, push_b, pset, rid, h;
        bit          rdy [2];
        bit          e_rsp [2];
        logic [31:0] e_rd [2];
        rdy[0] = m0_rdy;
        rdy[1] = m1_rdy;
        credit = (inf_n[k] + buf_n[k]) < MAX_OUT;
        c0     = m0_req && credit;
        c1     = m1_req && credit;
        e_sreq = c0 || c1;
        if (c0 && c1) win = (k == 1) ? 1'b0 : !rr_last[k];
        else          win = c1;
        acc = e_sreq && s_gnt[k];

        e_rsp[0] = 0; e_rsp[1] = 0;
        e_rd[0]  = last_rd[k][0];
        e_rd[1]  = last_rd[k][1];
        pop_b = 0; push_b = 0; pset = 0; rid = 0;
        if (buf_n[k] > 0) begin
            h        = buf_id[k][0];
            e_rsp[h] = 1;
            e_rd[h]  = buf_dat[k][0];
            pop_b    = rdy[h];
        end
        if (s_rsp[k]) begin
            if (inf_n[k] == 0) pset = 1;
            else begin
                rid = inf_id[k][0];
                if (buf_n[k] == 0 && rdy[rid]) begin
                    e_rsp[rid] = 1;
                    e_rd[rid]  = s_rdata[k];
                end else push_b = 1;
            end
        end

        chk(k, "s_req", 32'(s_req[k]), 32'(e_sreq));
        chk(k, "gnt0",  32'(m0_gnt[k]), 32'(acc && !win));
        chk(k, "gnt1",  32'(m1_gnt[k]), 32'(acc && win));
        if (e_sreq) begin
            chk(k, "s_addr",  s_addr[k],  win ? m1_addr : m0_addr);
            chk(k, "s_wrcs",  32'(s_wrcs[k]), 32'(win ? m1_wrcs : m0_wrcs));
            chk(k, "s_mask",  32'(s_mask[k]), 32'(win ? m1_mask : m0_mask));
            chk(k, "s_wdata", s_wdata[k], win ? m1_wdata : m0_wdata);
        end
        chk(k, "rsp0", 32'(m0_rsp[k]), 32'(e_rsp[0]));
        chk(k, "rsp1", 32'(m1_rsp[k]), 32'(e_rsp[1]));
        chk(k, "rd0",  m0_rd[k], e_rd[0]);
        chk(k, "rd1",  m1_rd[k], e_rd[1]);
        chk(k, "perr", 32'(perr[k]), 32'(perr_m[k]));
        chk(k, "s_rdy", 32'(s_rdy[k]), 1);

        if (e_rsp[0]) last_rd[k][0] = e_rd[0];
        if (e_rsp[1]) last_rd[k][1] = e_rd[1];
        if (pop_b) begin
            for (int i = 0; i < 7; i++) begin
                buf_id[k][i]  = buf_id[k][i+1];
                buf_dat[k][i] = buf_dat[k][i+1];
            end
            buf_n[k]--;
        end
        if (push_b) begin
            buf_id[k][buf_n[k]]  = rid;
            buf_dat[k][buf_n[k]] = s_rdata[k];
            buf_n[k]++;
        end
        if (s_rsp[k] && inf_n[k] > 0) begin
            for (int i = 0; i < 7; i++) inf_id[k][i] = inf_id[k][i+1];
            inf_n[k]--;
        end
        if (acc) begin
            inf_id[k][inf_n[k]] = win;
            inf_n[k]++;
            rr_last[k] = win;
        end
        if (pset) perr_m[k] = 1;
    endtask

    // Single compare process: every falling edge, both instances.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                model_reset(k);
                chk_reset_outs(k);
                pend_rsp[k] = 0;
                pend_dat[k] = '0;
            end else begin
                model_step(k);
                pend_rsp[k] = s_req[k] && s_gnt[k];
                if (dmode == 1) begin
                    pend_dat[k] = m0_gnt[k] ? 32'h11111111 : 32'h22222222;
                end else if (dmode == 2) begin
                    pend_dat[k] = (bp_idx[k] == 0) ? 32'hDEADBEEF : 32'h12345678;
                    if (pend_rsp[k]) bp_idx[k]++;
                end else begin
                    pend_dat[k] = $urandom;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            s_rsp[k]   = pend_rsp[k];
            s_rdata[k] = pend_dat[k];
        end
    endtask

    task automatic set_m(input bit r0, input bit r1, input bit y0, input bit y1, input bit g);
        m0_req = r0; m1_req = r1; m0_rdy = y0; m1_rdy = y1;
        s_gnt[0] = g; s_gnt[1] = g;
        m0_addr = $urandom; m1_addr = $urandom;
        m0_wdata = $urandom; m1_wdata = $urandom;
        m0_mask = 4'($urandom); m1_mask = 4'($urandom);
        m0_wrcs = 1'($urandom); m1_wrcs = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            start_cycle();
            set_m(0, 0, 1, 1, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        dmode = 0;
        set_m(0, 0, 1, 1, 1);
        for (int k = 0; k < 2; k++) begin
            s_rsp[k] = 0; s_rdata[k] = '0; pend_rsp[k] = 0; pend_dat[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk_reset_outs(k);
        rst = 1'b0;

        // Round-robin conflict: m0, m1, m0, m1 on instance 0; m0 always on instance 1.
        dmode = 1;
        for (int i = 0; i < 4; i++) begin
            start_cycle();
            set_m(1, 1, 1, 1, 1);
            #2;
            chk(0, "rr_gnt0", 32'(m0_gnt[0]), 32'(i % 2 == 0));
            chk(0, "rr_gnt1", 32'(m1_gnt[0]), 32'(i % 2 == 1));
            chk(1, "fx_gnt0", 32'(m0_gnt[1]), 1);
            if (i % 2 == 1) begin
                chk(0, "rr_rsp0", 32'(m0_rsp[0]), 1);
                chk(0, "rr_rd0",  m0_rd[0], 32'h11111111);
            end else if (i > 0) begin
                chk(0, "rr_rsp1", 32'(m1_rsp[0]), 1);
                chk(0, "rr_rd1",  m1_rd[0], 32'h22222222);
            end
        end
        start_cycle();
        set_m(0, 0, 1, 1, 1);
        #2;
        chk(0, "rr_last_rsp1", 32'(m1_rsp[0]), 1);
        chk(0, "rr_last_rd1",  m1_rd[0], 32'h22222222);
        dmode = 0;
        idle(3);

        // Fixed priority: m0 every cycle, then m1 right after m0 drops.
        for (int i = 0; i < 3; i++) begin
            start_cycle();
            set_m(1, 1, 1, 1, 1);
            #2;
            chk(1, "fx_hold_gnt0", 32'(m0_gnt[1]), 1);
            chk(1, "fx_hold_gnt1", 32'(m1_gnt[1]), 0);
        end
        start_cycle();
        set_m(0, 1, 1, 1, 1);
        #2;
        chk(1, "fx_m1_after", 32'(m1_gnt[1]), 1);
        idle(3);

        // Write pass-through from m1.
        start_cycle();
        set_m(0, 1, 1, 1, 1);
        m1_addr = 32'h00000104; m1_wrcs = 1'b1; m1_mask = 4'b0011; m1_wdata = 32'hA5A5A5A5;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "wr_addr",  s_addr[k], 32'h00000104);
            chk(k, "wr_wrcs",  32'(s_wrcs[k]), 1);
            chk(k, "wr_mask",  32'(s_mask[k]), 32'h3);
            chk(k, "wr_wdata", s_wdata[k], 32'hA5A5A5A5);
            chk(k, "wr_gnt1",  32'(m1_gnt[k]), 1);
        end
        start_cycle();
        set_m(0, 0, 1, 1, 1);
        #2;
        for (int k = 0; k < 2; k++) chk(k, "wr_rsp1", 32'(m1_rsp[k]), 1);
        idle(3);

        // Backpressure on m0 with two credits.
        dmode = 2;
        bp_idx[0] = 0; bp_idx[1] = 0;
        start_cycle(); set_m(1, 0, 0, 1, 1); #2;
        for (int k = 0; k < 2; k++) chk(k, "bp_a_gnt0", 32'(m0_gnt[k]), 1);
        start_cycle(); set_m(1, 0, 0, 1, 1); #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "bp_b_gnt0", 32'(m0_gnt[k]), 1);
            chk(k, "bp_b_rsp0", 32'(m0_rsp[k]), 0);
        end
        start_cycle(); set_m(1, 0, 0, 1, 1); #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "bp_c_sreq", 32'(s_req[k]), 0);
            chk(k, "bp_c_rsp0", 32'(m0_rsp[k]), 1);
            chk(k, "bp_c_rd0",  m0_rd[k], 32'hDEADBEEF);
        end
        start_cycle(); set_m(0, 0, 1, 1, 1); #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "bp_d_rsp0", 32'(m0_rsp[k]), 1);
            chk(k, "bp_d_rd0",  m0_rd[k], 32'hDEADBEEF);
        end
        start_cycle(); set_m(0, 0, 1, 1, 1); #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "bp_e_rsp0", 32'(m0_rsp[k]), 1);
            chk(k, "bp_e_rd0",  m0_rd[k], 32'h12345678);
        end
        start_cycle(); set_m(0, 0, 1, 1, 1); #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "bp_f_rsp0", 32'(m0_rsp[k]), 0);
            chk(k, "bp_f_hold", m0_rd[k], 32'h12345678);
        end
        dmode = 0;
        idle(3);

        // Randomized traffic against the model.
        repeat (3000) begin
            start_cycle();
            set_m(1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, 1'b1);
            s_gnt[0] = $urandom_range(0, 3) != 0;
            s_gnt[1] = $urandom_range(0, 3) != 0;
        end
        idle(6);

        // Spurious slave response with nothing in flight.
        start_cycle();
        set_m(0, 0, 1, 1, 1);
        s_rsp[0] = 1'b1; s_rsp[1] = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "sp_rsp0", 32'(m0_rsp[k]), 0);
            chk(k, "sp_rsp1", 32'(m1_rsp[k]), 0);
        end
        start_cycle(); set_m(0, 0, 1, 1, 1); #2;
        for (int k = 0; k < 2; k++) chk(k, "sp_perr", 32'(perr[k]), 1);
        idle(3);
        #2;
        for (int k = 0; k < 2; k++) chk(k, "sp_perr_sticky", 32'(perr[k]), 1);

        // Async reset with one in flight and one buffered.
        start_cycle(); set_m(1, 0, 0, 1, 1);
        start_cycle(); set_m(1, 0, 0, 1, 1);
        start_cycle(); set_m(0, 0, 0, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk_reset_outs(k);
        start_cycle();
        s_rsp[0] = 1'b0; s_rsp[1] = 1'b0;
        rst = 1'b0;
        set_m(1, 1, 1, 1, 1);
        #2;
        chk(0, "post_rst_gnt0", 32'(m0_gnt[0]), 1);
        chk(0, "post_rst_gnt1", 32'(m1_gnt[0]), 0);
        chk(1, "post_rst_fx_gnt0", 32'(m0_gnt[1]), 1);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rib_tcm_arbiter.md
Name: rib_tcm_arbiter

Overview:
Two-master to one-slave RIB arbiter that lets the core data port (m0) and a secondary master such as DMA or debug (m1) share one TCM controller.
- Arbitrates requests, muxes the winner's request onto the slave port, and tracks in-flight transactions in an ID FIFO.
- Routes each slave response back to its owner, buffering it when the owner deasserts rdy.
- Sits between the bus masters and the DTCM controller, whose rsp arrives one cycle after gnt with no backpressure of its own.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with m0 highest.
- MAX_OUT, 2, total credits, i.e. in-flight plus buffered responses. Legal values are 1..4.
- AW, 32, address width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_mX_addr  in  AW  master X address (X = 0, 1; applies to every i_mX_/o_mX_ port)
- i_mX_wrcs  in  1  master X read/write select, 1 = write
- i_mX_mask  in  4  master X byte-write mask
- i_mX_wdata  in  32  master X write data
- i_mX_req  in  1  master X request
- o_mX_gnt  out  1  master X request accepted
- o_mX_rsp  out  1  master X response valid
- o_mX_rdata  out  32  master X read data
- i_mX_rdy  in  1  master X ready to take a response
- o_s_addr, o_s_wrcs, o_s_mask, o_s_wdata  out  AW/1/4/32  muxed request fields to the slave
- o_s_req  out  1  slave request
- i_s_gnt  in  1  slave grant
- i_s_rsp  in  1  slave response pulse
- i_s_rdata  in  32  slave read data
- o_s_rdy  out  1  tied to 1; credits guarantee space for every response
- o_proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values:
  - all o_mX_gnt/rsp = 0, o_mX_rdata = 0, o_s_req = 0, o_proto_err = 0.
  - ID FIFO and response FIFO empty; credit count = 0.
  - rr_last = 1, so m0 wins first.
- credit_ok = (inflight_cnt + resp_cnt) < MAX_OUT. Both counts are registered values. There is no same-cycle credit reuse beyond those registered counts.
- Arbitration is combinational each cycle:
  - Candidates are masters with req high, and only when credit_ok.
  - Round-robin: on conflict the master != rr_last wins.
  - Fixed priority: m0 wins on conflict.
  - o_s_req = any candidate; o_s_* fields = winner's fields; o_winner_gnt = i_s_gnt & o_s_req; the loser's gnt = 0.
- Accept (o_s_req & i_s_gnt):
  - Push the winner ID into the ID FIFO (depth MAX_OUT); inflight_cnt++.
  - rr_last <= winner.
- Response (i_s_rsp):
  - Pop the ID FIFO head; inflight_cnt--.
  - Bypass: if the response FIFO is empty and the owner's rdy = 1, assert o_owner_rsp with o_owner_rdata = i_s_rdata in the same cycle. There is no buffering in this case.
  - Otherwise push {id, rdata} into the response FIFO.
- Response FIFO head presentation:
  - Drive o_id_rsp = 1 with rdata from the head.
  - Pop when that master's rdy = 1.
  - Responses stay in order: a bypass is forbidden while the FIFO is non-empty.
- Simultaneous accept and response in one cycle: inflight_cnt is unchanged. Back-to-back accepts on consecutive cycles are required at MAX_OUT >= 2.
- Simultaneous FIFO pop and new push: both occur; resp_cnt is unchanged.
- i_s_rsp while the ID FIFO is empty: ignore the response, set o_proto_err (held until reset), leave counts unchanged.
- o_mX_rdata holds its last value when rsp = 0.
- Reset mid-operation: all state clears asynchronously and in-flight transactions are discarded. The slave reissues nothing.

Decomposition:
- Shared package (rib_pkg):
  - RIB field widths (mask 4, data 32), master ID type (1 bit), PRIO_RR and PRIO_FIXED constants.
  - Response entry struct {id, rdata}.
- One natural sub-module: rib_sync_fifo, parameterised width/depth, with push, pop, head, count, full and empty outputs.
  - Instantiated twice: ID FIFO at width 1, response FIFO at width 33.

Test Plan:
- Round-robin conflict (PRIO_MODE=0): m0 and m1 both hold req for 4 cycles, slave gnt=1 → grants go m0, m1, m0, m1. Responses return the matching rdata (e.g. 0x11111111 to m0, 0x22222222 to m1) one cycle after each grant.
- Fixed priority (PRIO_MODE=1): both req continuously for 3 cycles → m0 granted every cycle and m1 never; after m0 drops req, m1 is granted the next cycle.
- Backpressure: m0 read with i_m0_rdy=0 for 3 cycles, MAX_OUT=2:
  - rdata 0xDEADBEEF is buffered and o_m0_rsp is held with 0xDEADBEEF.
  - The second request is granted, then o_s_req=0 until m0 takes a response.
  - Responses are delivered in order once rdy=1.
- Write pass-through: m1 write addr 0x00000104, mask 4'b0011, wdata 0xA5A5A5A5 → o_s_* carry exactly these values and o_m1_rsp pulses the next cycle.
- Spurious slave rsp with nothing in flight → o_proto_err=1 and stays 1; no o_mX_rsp asserted.
- Async reset asserted mid-transaction (one in flight, one buffered) → all outputs 0 immediately, counts 0; the first post-reset request is granted to m0.
